// File: rtl/output_pulse_driver_if.sv
// Event-strobe in, timed-pulse out bundle for output_pulse_driver; ovf/ovf_clr exist only
// when OUTPUT_PULSE_OVF_EN is defined.
interface output_pulse_driver_if #(
  parameter int PEND_W = 4
);
  logic              trig;
  logic              o;
  logic              busy;
  logic [PEND_W-1:0] pending;
`ifdef OUTPUT_PULSE_OVF_EN
  logic              ovf;
  logic              ovf_clr;
`endif

  // master is the event source / status observer, slave is the pulse driver
  modport master (
    output trig,
`ifdef OUTPUT_PULSE_OVF_EN
    output ovf_clr,
    input  ovf,
`endif
    input  o,
    input  busy,
    input  pending
  );

  modport slave (
    input  trig,
`ifdef OUTPUT_PULSE_OVF_EN
    input  ovf_clr,
    output ovf,
`endif
    output o,
    output busy,
    output pending
  );
endinterface

// File: rtl/output_pulse_driver.sv
// Turns single-cycle trig strobes into HIGH_CYCLES-wide pulses separated by >= GAP_CYCLES idle;
// latency trig@t -> o active @t+1; overlapping events queue (saturating), overflow flag via OUTPUT_PULSE_OVF_EN.
// No backpressure: trig is always accepted; events beyond the queue limit are dropped.
module output_pulse_driver #(
  parameter int       HIGH_CYCLES = 1_000_000,
  parameter int       GAP_CYCLES  = 1_000_000,
  parameter int       PEND_W      = 4,
  parameter bit       IDLE_LEVEL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output_pulse_driver_if.slave   bus
);

  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              o_q, o_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              start;
  logic              consume;
  logic              drop;

  assign start = bus.trig | (pending_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_q       <= IDLE_LEVEL;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      pending_q <= pending_d;
    end
  end

  // Pulse sequencing: a new pulse may start from IDLE, or straight out of an expired GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          o_d     = ~IDLE_LEVEL;
          cnt_d   = HIGH_LOAD;
          consume = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = GAP;
          o_d     = IDLE_LEVEL;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (start) begin
          state_d = ACTIVE;
          o_d     = ~IDLE_LEVEL;
          cnt_d   = HIGH_LOAD;
          consume = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        o_d     = IDLE_LEVEL;
        cnt_d   = '0;
      end
    endcase
  end

  // A trig consumed in its own cycle nets to zero and never touches the queue.
  always_comb begin
    pending_d = pending_q;
    drop      = 1'b0;
    case ({bus.trig, consume})
      2'b10: begin
        if (pending_q == PEND_MAX) begin
          drop = 1'b1;
        end else begin
          pending_d = pending_q + PEND_ONE;
        end
      end
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase
  end

  assign bus.o       = o_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.pending = pending_q;

`ifdef OUTPUT_PULSE_OVF_EN
  logic ovf_q;

  // Set beats a simultaneous clear so a drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= drop | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
